alu_result_fifo: RTL and testbench

Buffers the registered outputs of the ALU (`o_result`, `o_flag`) so that a slower consumer can take them later. Each ALU result travels with its flags as one entry through a DEPTH-entry first-in-first-out queue (FIFO). Writes and reads each use a valid/ready handshake. The block also keeps a sticky OR of all accepted flags and a sticky overflow indicator for dropped writes, both readable by the control sequencer.

---
 rtl/alu_result_fifo.sv | 92 +++++++++
 tb/tb_alu_result_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO that holds ALU results and their flags for a slower consumer.
// It also keeps a sticky OR of accepted flags and a sticky overflow bit for dropped writes.
module alu_result_fifo #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned FLAG_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    input  logic [DATA_W-1:0]          i_result,
    input  logic [FLAG_W-1:0]          i_flag,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_result,
    output logic [FLAG_W-1:0]          o_flag,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [FLAG_W-1:0]          o_sticky_flag,
    output logic                       o_overflow,
    input  logic                       i_sticky_clr
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flag;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FLAG_W-1:0] sticky_q, sticky_d;
    logic              overflow_q, overflow_d;

    logic   full, empty, push, pop, drop;
    entry_t head;

    // The extra pointer MSB separates full from empty when the low bits match.
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = i_valid & ~full;
    assign pop   = ~empty & i_ready;
    assign drop  = i_valid & full;

    // Next-state logic for pointers and sticky status
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sticky_d   = i_sticky_clr ? '0 : sticky_q;
        overflow_d = (i_sticky_clr ? 1'b0 : overflow_q) | drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            sticky_d = sticky_d | i_flag;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sticky_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sticky_q   <= sticky_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array carries no reset; the head is gated while empty instead.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{result: i_result, flag: i_flag};
        end
    end

    assign head          = mem_q[rd_ptr_q[AW-1:0]];
    assign o_ready       = ~full;
    assign o_valid       = ~empty;
    assign o_result      = empty ? '0 : head.result;
    assign o_flag        = empty ? '0 : head.flag;
    assign o_count       = wr_ptr_q - rd_ptr_q;
    assign o_sticky_flag = sticky_q;
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: a queue model predicts head, count,
// handshake and sticky status each cycle.
module tb_alu_result_fifo;
    localparam int unsigned DATA_W = 10;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned DEPTH  = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_valid;
    logic [DATA_W-1:0] i_result;
    logic [FLAG_W-1:0] i_flag;
    logic              o_ready;
    logic              o_valid;
    logic [DATA_W-1:0] o_result;
    logic [FLAG_W-1:0] o_flag;
    logic              i_ready;
    logic [2:0]        o_count;
    logic [FLAG_W-1:0] o_sticky_flag;
    logic              o_overflow;
    logic              i_sticky_clr;

    int errors = 0;
    int checks = 0;

    logic [DATA_W+FLAG_W-1:0] sb_q[$];
    logic [FLAG_W-1:0]        sticky_m;
    logic                     ovf_m;

    alu_result_fifo #(.DATA_W(DATA_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_result      (i_result),
        .i_flag        (i_flag),
        .o_ready       (o_ready),
        .o_valid       (o_valid),
        .o_result      (o_result),
        .o_flag        (o_flag),
        .i_ready       (i_ready),
        .o_count       (o_count),
        .o_sticky_flag (o_sticky_flag),
        .o_overflow    (o_overflow),
        .i_sticky_clr  (i_sticky_clr)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: check current outputs against the model, apply inputs, advance.
    task automatic step(input logic v, input logic [DATA_W-1:0] r, input logic [FLAG_W-1:0] f,
                        input logic rdy, input logic clr);
        logic do_push, do_pop, do_drop;
        i_valid = v; i_result = r; i_flag = f; i_ready = rdy; i_sticky_clr = clr;
        #1;
        check("ready", 32'(o_ready), 32'(sb_q.size() < DEPTH));
        check("valid", 32'(o_valid), 32'(sb_q.size() > 0));
        check("count", 32'(o_count), 32'(sb_q.size()));
        if (sb_q.size() > 0) check("head", 32'({o_result, o_flag}), 32'(sb_q[0]));
        else                 check("head_empty", 32'({o_result, o_flag}), 32'(0));
        do_pop  = (sb_q.size() > 0) && rdy;
        do_push = v && (sb_q.size() < DEPTH);
        do_drop = v && (sb_q.size() >= DEPTH);
        sticky_m = (clr ? 4'b0 : sticky_m) | (do_push ? f : 4'b0);
        ovf_m    = (clr ? 1'b0 : ovf_m) | do_drop;
        if (do_pop)  void'(sb_q.pop_front());
        if (do_push) sb_q.push_back({r, f});
        @(posedge i_clk);
        #1;
        check("sticky", 32'(o_sticky_flag), 32'(sticky_m));
        check("overflow", 32'(o_overflow), 32'(ovf_m));
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, rdy, 1'b0);
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_result = '0; i_flag = '0;
        i_ready = 1'b0; i_sticky_clr = 1'b0;
        sticky_m = '0; ovf_m = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_count", 32'(o_count), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_ready", 32'(o_ready), 1);
        check("rst_head", 32'({o_result, o_flag}), 0);
        check("rst_sticky", 32'(o_sticky_flag), 0);
        check("rst_ovf", 32'(o_overflow), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Single entry: -9 with flag 0100, then pop
        step(1'b1, 10'h3F7, 4'b0100, 1'b0, 1'b0);
        check("single_valid", 32'(o_valid), 1);
        check("single_result", 32'(o_result), 32'(10'h3F7));
        check("single_flag", 32'(o_flag), 32'(4'b0100));
        check("single_count", 32'(o_count), 1);
        idle(1'b1);
        check("single_pop_valid", 32'(o_valid), 0);
        check("single_pop_head", 32'({o_result, o_flag}), 0);

        // Fill, overflow, drain
        step(1'b1, 10'd4,   4'h1, 1'b0, 1'b0);
        step(1'b1, 10'd1,   4'h2, 1'b0, 1'b0);
        step(1'b1, 10'd0,   4'h3, 1'b0, 1'b0);
        step(1'b1, 10'h3F7, 4'h4, 1'b0, 1'b0);
        check("fill_ready", 32'(o_ready), 0);
        check("fill_count", 32'(o_count), 4);
        step(1'b1, 10'd8,   4'h5, 1'b0, 1'b0);
        check("fill_ovf", 32'(o_overflow), 1);
        check("fill_count_after_drop", 32'(o_count), 4);
        repeat (5) idle(1'b1);

        // Two stored, then 10 cycles of simultaneous push and pop
        step(1'b1, 10'h100, 4'h6, 1'b0, 1'b1);
        step(1'b1, 10'h101, 4'h7, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 10'(10'h200 + i), 4'(i), 1'b1, 1'b0);
            check("sim_count", 32'(o_count), 2);
        end
        repeat (3) idle(1'b1);

        // Push while full with a pop in the same cycle
        for (int i = 0; i < 4; i++) step(1'b1, 10'(10'h050 + i), 4'h0, 1'b0, 1'b0);
        step(1'b1, 10'h3FF, 4'hF, 1'b1, 1'b0);
        check("fullpop_count", 32'(o_count), 3);
        check("fullpop_ovf", 32'(o_overflow), 1);
        repeat (4) idle(1'b1);

        // Sticky flags and clear
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 10'h011, 4'b0001, 1'b0, 1'b0);
        step(1'b1, 10'h012, 4'b1000, 1'b0, 1'b0);
        check("sticky_or", 32'(o_sticky_flag), 32'(4'b1001));
        step(1'b1, 10'h013, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 10'h014, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 10'h015, 4'b0010, 1'b0, 1'b1);
        check("clr_full_sticky", 32'(o_sticky_flag), 0);
        check("clr_full_ovf", 32'(o_overflow), 1);
        idle(1'b1);
        step(1'b1, 10'h016, 4'b0010, 1'b0, 1'b1);
        check("clr_push_sticky", 32'(o_sticky_flag), 32'(4'b0010));
        check("clr_push_ovf", 32'(o_overflow), 0);

        // Arrange 3 entries with overflow set, then reset between edges
        step(1'b1, 10'h020, 4'h1, 1'b0, 1'b0);
        step(1'b1, 10'h021, 4'h1, 1'b0, 1'b0);
        step(1'b1, 10'h022, 4'h1, 1'b1, 1'b0);
        check("pre_rst_count", 32'(o_count), 3);
        check("pre_rst_ovf", 32'(o_overflow), 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_count", 32'(o_count), 0);
        check("arst_valid", 32'(o_valid), 0);
        check("arst_ready", 32'(o_ready), 1);
        check("arst_ovf", 32'(o_overflow), 0);
        check("arst_sticky", 32'(o_sticky_flag), 0);
        check("arst_head", 32'({o_result, o_flag}), 0);
        sb_q.delete();
        sticky_m = '0; ovf_m = 1'b0;
        #1;
        i_rst_n = 1'b1;

        // Traffic after reset release
        step(1'b1, 10'h1AB, 4'h9, 1'b0, 1'b0);
        step(1'b1, 10'h0CD, 4'h3, 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
